// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), counter type and colour encoding
// for the scan controller and its axis counters.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_PW_DEF      = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_PW_DEF      = 2;
  localparam int V_BP_DEF      = 33;

  function automatic int axis_total(input int vis, input int fp, input int pw, input int bp);
    return vis + fp + pw + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_VISIBLE_DEF, H_FP_DEF, H_PW_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_VISIBLE_DEF, V_FP_DEF, V_PW_DEF, V_BP_DEF);

  typedef logic [CNT_W-1:0] count_t;

  // Frame-buffer colour word: bit2 = R, bit1 = G, bit0 = B.
  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } colour_t;

  localparam colour_t COLOUR_BLACK = '0;

endpackage

// File: rtl/vga_scan_controller_if.sv
// Frame-buffer read port: the controller issues address/strobe, the buffer
// returns the colour one Clock later.
interface vga_scan_controller_if #(
  parameter int ADDR_W = 13
) ();
  logic [ADDR_W-1:0] oRdAddr;
  logic              oRdEn;
  logic [2:0]        iRdData;

  modport master (output oRdAddr, output oRdEn, input iRdData);
  modport slave  (input oRdAddr, input oRdEn, output iRdData);
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping position counter that steps on advance and decodes
// the visible and sync regions of the current position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS = H_VISIBLE_DEF,
  parameter int FP  = H_FP_DEF,
  parameter int PW  = H_PW_DEF,
  parameter int BP  = H_BP_DEF
) (
  input  logic   Clock,
  input  logic   Reset,
  input  logic   advance,
  output count_t count,
  output logic   wrap,
  output logic   visible,
  output logic   syncActive
);

  localparam int     TOTAL      = axis_total(VIS, FP, PW, BP);
  localparam count_t LAST       = count_t'(TOTAL - 1);
  localparam count_t VIS_END    = count_t'(VIS);
  localparam count_t SYNC_START = count_t'(VIS + FP);
  localparam count_t SYNC_END   = count_t'(VIS + FP + PW);

  count_t count_reg;
  logic   at_end;

  assign at_end     = (count_reg == LAST);
  assign wrap       = advance & at_end;
  assign visible    = (count_reg < VIS_END);
  assign syncActive = (count_reg >= SYNC_START) && (count_reg < SYNC_END);
  assign count      = count_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (advance) begin
      count_reg <= at_end ? '0 : count_reg + count_t'(1);
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan controller: pixel-tick divider, H/V scan counters, frame-buffer read
// scheduling and a one-tick registered output stage for sync, enable and colour.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = H_VISIBLE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_PW        = H_PW_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_VISIBLE   = V_VISIBLE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_PW        = V_PW_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int SCALE_SHIFT = 3,
  parameter int XA_W        = 7,
  parameter int YA_W        = 6
) (
  input  logic   Clock,
  input  logic   Reset,
  input  logic   iEnable,
  vga_scan_controller_if.master fb,
  output count_t oPixelX,
  output count_t oPixelY,
  output logic   oHsync,
  output logic   oVsync,
  output logic   oRed,
  output logic   oGreen,
  output logic   oBlue,
  output logic   oDisplayEn,
  output logic   oFrameStart
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic             scan_clr;
  logic             h_wrap, h_vis, h_sync;
  logic             v_wrap, v_vis, v_sync;
  logic             pixel_vis;
  logic             rd_en;
  count_t           h_count, v_count;
  colour_t          colour_reg;

  // Disabling behaves like reset so the next enabled frame restarts at (0,0).
  assign scan_clr = Reset | ~iEnable;
  assign tick     = iEnable & (div_reg == DIV_LAST);

  always_ff @(posedge Clock) begin
    if (scan_clr || tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .VIS(H_VISIBLE), .FP(H_FP), .PW(H_PW), .BP(H_BP)
  ) u_h_counter (
    .Clock(Clock), .Reset(scan_clr), .advance(tick),
    .count(h_count), .wrap(h_wrap), .visible(h_vis), .syncActive(h_sync)
  );

  vga_axis_counter #(
    .VIS(V_VISIBLE), .FP(V_FP), .PW(V_PW), .BP(V_BP)
  ) u_v_counter (
    .Clock(Clock), .Reset(scan_clr), .advance(h_wrap),
    .count(v_count), .wrap(v_wrap), .visible(v_vis), .syncActive(v_sync)
  );

  assign pixel_vis  = h_vis & v_vis;
  assign rd_en      = iEnable & pixel_vis;
  assign fb.oRdEn   = rd_en;
  assign fb.oRdAddr = rd_en ? {YA_W'(v_count >> SCALE_SHIFT), XA_W'(h_count >> SCALE_SHIFT)} : '0;
  assign oPixelX    = h_count;
  assign oPixelY    = v_count;

  // Counters are stable for CLK_DIV >= 2 Clocks, so read data for the current
  // pixel has already returned when the tick registers it.
  always_ff @(posedge Clock) begin
    if (scan_clr) begin
      oHsync      <= 1'b1;
      oVsync      <= 1'b1;
      oDisplayEn  <= 1'b0;
      oFrameStart <= 1'b0;
      colour_reg  <= COLOUR_BLACK;
    end else begin
      oFrameStart <= v_wrap;
      if (tick) begin
        oHsync     <= ~h_sync;
        oVsync     <= ~v_sync;
        oDisplayEn <= pixel_vis;
        colour_reg <= pixel_vis ? colour_t'(fb.iRdData) : COLOUR_BLACK;
      end
    end
  end

  assign oRed   = colour_reg.red;
  assign oGreen = colour_reg.green;
  assign oBlue  = colour_reg.blue;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: a default 640x480 instance for line timing and read addressing,
// and a small-raster instance (28x18 totals) for whole-frame behaviour.
module tb_vga_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-timing instance
  logic       rst_d = 1'b1, en_d = 1'b0;
  logic [9:0] px_d, py_d;
  logic       hs_d, vs_d, r_d, g_d, b_d, de_d, fs_d;
  vga_scan_controller_if #(.ADDR_W(13)) fb_d ();

  vga_scan_controller dut_d (
    .Clock(clk), .Reset(rst_d), .iEnable(en_d), .fb(fb_d),
    .oPixelX(px_d), .oPixelY(py_d), .oHsync(hs_d), .oVsync(vs_d),
    .oRed(r_d), .oGreen(g_d), .oBlue(b_d), .oDisplayEn(de_d), .oFrameStart(fs_d)
  );

  always @(posedge clk) fb_d.iRdData <= fb_d.oRdAddr[2:0];

  // Small-raster instance: H 20/2/4/2 (total 28), V 12/2/2/2 (total 18)
  localparam int SH_T = 28;
  localparam int SV_T = 18;
  logic       rst_s = 1'b1, en_s = 1'b0, force7_s = 1'b0;
  logic [9:0] px_s, py_s;
  logic       hs_s, vs_s, r_s, g_s, b_s, de_s, fs_s;
  vga_scan_controller_if #(.ADDR_W(13)) fb_s ();

  vga_scan_controller #(
    .CLK_DIV(2), .H_VISIBLE(20), .H_FP(2), .H_PW(4), .H_BP(2),
    .V_VISIBLE(12), .V_FP(2), .V_PW(2), .V_BP(2),
    .SCALE_SHIFT(3), .XA_W(7), .YA_W(6)
  ) dut_s (
    .Clock(clk), .Reset(rst_s), .iEnable(en_s), .fb(fb_s),
    .oPixelX(px_s), .oPixelY(py_s), .oHsync(hs_s), .oVsync(vs_s),
    .oRed(r_s), .oGreen(g_s), .oBlue(b_s), .oDisplayEn(de_s), .oFrameStart(fs_s)
  );

  always @(posedge clk) fb_s.iRdData <= force7_s ? 3'b111 : fb_s.oRdAddr[2:0];

  task automatic restart_s();
    rst_s = 1'b1; en_s = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_d = 1'b1; en_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (px_d !== 10'd0) begin errors++; $display("FAIL reset_px got %0d want 0", px_d); end
    checks++; if (py_d !== 10'd0) begin errors++; $display("FAIL reset_py got %0d want 0", py_d); end
    checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hs_d); end
    checks++; if (vs_d !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vs_d); end
    checks++; if ({r_d, g_d, b_d} !== 3'b000) begin errors++; $display("FAIL reset_rgb got %b want 000", {r_d, g_d, b_d}); end
    checks++; if (de_d !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", de_d); end
    checks++; if (fs_d !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", fs_d); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hsync_timing();
    int n, m, p;
    @(negedge clk); rst_d = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (hs_d && n < 3000);
    checks++; if (n != 1314) begin errors++; $display("FAIL hsync_first_fall got %0d want 1314", n); end
    m = 0;
    do begin @(posedge clk); #1; m++; end while (!hs_d && m < 3000);
    checks++; if (m != 192) begin errors++; $display("FAIL hsync_low_width got %0d want 192", m); end
    p = 0;
    do begin @(posedge clk); #1; p++; end while (hs_d && p < 3000);
    checks++; if (m + p != 1600) begin errors++; $display("FAIL hsync_period got %0d want 1600", m + p); end
    $display("test_hsync_timing: fall=%0d low=%0d period=%0d", n, m, m + p);
  endtask

  task automatic test_read_addr();
    bit found;
    @(negedge clk); rst_d = 1'b1;
    @(negedge clk); rst_d = 1'b0;
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (px_d == 10'd17 && py_d == 10'd9) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rd_reach_17_9 got timeout want reached"); end
    checks++; if (fb_d.oRdAddr !== 13'd130) begin errors++; $display("FAIL rd_addr got %0d want 130", fb_d.oRdAddr); end
    checks++; if (fb_d.oRdEn !== 1'b1) begin errors++; $display("FAIL rd_en got %b want 1", fb_d.oRdEn); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (px_d == 10'd18) found = 1;
    end
    checks++; if ({r_d, g_d, b_d} !== 3'b010) begin errors++; $display("FAIL rd_rgb got %b want 010", {r_d, g_d, b_d}); end
    checks++; if (de_d !== 1'b1) begin errors++; $display("FAIL rd_de got %b want 1", de_d); end
    $display("test_read_addr: addr=%0d rgb=%b", 130, {r_d, g_d, b_d});
  endtask

  task automatic test_frame();
    int vs_fall, vs_low, fs1, fs2, fs_cnt, de_cnt;
    force7_s = 1'b0;
    restart_s();
    vs_fall = 0; vs_low = 0; fs1 = 0; fs2 = 0; fs_cnt = 0; de_cnt = 0;
    for (int n = 1; n <= 2100; n++) begin
      @(posedge clk); #1;
      if (!vs_s && vs_fall == 0) vs_fall = n;
      if (!vs_s && n <= 1008) vs_low++;
      if (de_s && n <= 1008) de_cnt++;
      if (fs_s) begin
        fs_cnt++;
        if (fs1 == 0) fs1 = n; else if (fs2 == 0) fs2 = n;
      end
    end
    checks++; if (vs_fall != 786) begin errors++; $display("FAIL vsync_first_fall got %0d want 786", vs_fall); end
    checks++; if (vs_low != 112) begin errors++; $display("FAIL vsync_low_width got %0d want 112", vs_low); end
    checks++; if (fs1 != 1008) begin errors++; $display("FAIL frame_start_first got %0d want 1008", fs1); end
    checks++; if (fs2 != 2016) begin errors++; $display("FAIL frame_start_second got %0d want 2016", fs2); end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL frame_start_pulses got %0d want 2", fs_cnt); end
    checks++; if (de_cnt != 480) begin errors++; $display("FAIL display_en_clocks got %0d want 480", de_cnt); end
    $display("test_frame: vs_fall=%0d vs_low=%0d fs=%0d,%0d de=%0d", vs_fall, vs_low, fs1, fs2, de_cnt);
  endtask

  task automatic test_blanking();
    int pos_bad, de_bad, rgb_bad, rd_bad, sync_bad;
    int xe, ye, xp, yp;
    bit vis_e, vis_p;
    force7_s = 1'b1;
    restart_s();
    pos_bad = 0; de_bad = 0; rgb_bad = 0; rd_bad = 0; sync_bad = 0;
    for (int k = 1; k <= 1008; k++) begin
      @(negedge clk);
      xe = (k / 2) % SH_T;
      ye = ((k / 2) / SH_T) % SV_T;
      vis_e = (xe < 20) && (ye < 12);
      if (px_s != 10'(xe) || py_s != 10'(ye)) pos_bad++;
      if (fb_s.oRdEn !== vis_e) rd_bad++;
      if (!vis_e && fb_s.oRdAddr !== 13'd0) rd_bad++;
      if (k >= 2) begin
        xp = ((k / 2) - 1) % SH_T;
        yp = (((k / 2) - 1) / SH_T) % SV_T;
        vis_p = (xp < 20) && (yp < 12);
        if (hs_s !== !(xp >= 22 && xp < 26)) sync_bad++;
        if (vs_s !== !(yp >= 14 && yp < 16)) sync_bad++;
      end else begin
        vis_p = 1'b0;
      end
      if (de_s !== vis_p) de_bad++;
      if ({r_s, g_s, b_s} !== (vis_p ? 3'b111 : 3'b000)) rgb_bad++;
    end
    force7_s = 1'b0;
    checks++; if (pos_bad != 0) begin errors++; $display("FAIL blank_counters got %0d bad want 0", pos_bad); end
    checks++; if (rd_bad != 0) begin errors++; $display("FAIL blank_rd_en got %0d bad want 0", rd_bad); end
    checks++; if (de_bad != 0) begin errors++; $display("FAIL blank_de got %0d bad want 0", de_bad); end
    checks++; if (rgb_bad != 0) begin errors++; $display("FAIL blank_rgb got %0d bad want 0", rgb_bad); end
    checks++; if (sync_bad != 0) begin errors++; $display("FAIL blank_syncs got %0d bad want 0", sync_bad); end
    $display("test_blanking: bad pos=%0d rd=%0d de=%0d rgb=%0d sync=%0d", pos_bad, rd_bad, de_bad, rgb_bad, sync_bad);
  endtask

  task automatic test_reset_midline();
    bit found;
    int n, m;
    restart_s();
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (px_s == 10'd23 && py_s == 10'd14) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach got timeout want reached"); end
    checks++; if (hs_s !== 1'b0) begin errors++; $display("FAIL midrst_pre_hsync got %b want 0", hs_s); end
    checks++; if (vs_s !== 1'b0) begin errors++; $display("FAIL midrst_pre_vsync got %b want 0", vs_s); end
    rst_s = 1'b1;
    @(posedge clk); #1;
    checks++; if (px_s !== 10'd0) begin errors++; $display("FAIL midrst_px got %0d want 0", px_s); end
    checks++; if (py_s !== 10'd0) begin errors++; $display("FAIL midrst_py got %0d want 0", py_s); end
    checks++; if (hs_s !== 1'b1) begin errors++; $display("FAIL midrst_hsync got %b want 1", hs_s); end
    checks++; if (vs_s !== 1'b1) begin errors++; $display("FAIL midrst_vsync got %b want 1", vs_s); end
    checks++; if ({r_s, g_s, b_s} !== 3'b000) begin errors++; $display("FAIL midrst_rgb got %b want 000", {r_s, g_s, b_s}); end
    @(negedge clk); rst_s = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (hs_s && n < 500);
    checks++; if (n != 46) begin errors++; $display("FAIL midrst_hsync_fall got %0d want 46", n); end
    m = 0;
    do begin @(posedge clk); #1; m++; end while (!hs_s && m < 500);
    checks++; if (m != 8) begin errors++; $display("FAIL midrst_hsync_width got %0d want 8", m); end
    $display("test_reset_midline: fall=%0d width=%0d", n, m);
  endtask

  task automatic test_enable_drop();
    bit found;
    int idle_bad, n;
    restart_s();
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (px_s == 10'd10 && py_s == 10'd3) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL endrop_reach got timeout want reached"); end
    en_s = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (px_s !== 10'd0 || py_s !== 10'd0 || hs_s !== 1'b1 || vs_s !== 1'b1) idle_bad++;
      if ({r_s, g_s, b_s} !== 3'b000 || de_s !== 1'b0 || fb_s.oRdEn !== 1'b0 || fb_s.oRdAddr !== 13'd0) idle_bad++;
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL endrop_idle got %0d bad want 0", idle_bad); end
    en_s = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (hs_s && n < 500);
    checks++; if (n != 46) begin errors++; $display("FAIL endrop_hsync_fall got %0d want 46", n); end
    $display("test_enable_drop: idle_bad=%0d fall=%0d", idle_bad, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hsync_timing();
    test_read_addr();
    test_frame();
    test_blanking();
    test_reset_midline();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Sequences the VGA display path. Divides the system clock into a pixel tick, runs the horizontal and vertical scan counters, and drives HSync/VSync. It issues one read per visible pixel to a synchronous-read frame buffer and registers the returned 3-bit colour onto the RGB pins, forced to black during blanking. It replaces the free-running state-sequenced sync generator as the single owner of display timing and frame-buffer read scheduling.

Parameters:
CLK_DIV, 2, system clocks per pixel tick (>=2)
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PW, 96, HSync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_PW, 2, VSync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_SHIFT, 3, log2 of pixel replication factor into frame buffer
XA_W, 7, address bits for scaled column (80 columns)
YA_W, 6, address bits for scaled row (60 rows)

Ports:
Clock  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high
iEnable  in  1  scan run enable
iRdData  in  3  frame-buffer colour {R,G,B}, valid one Clock after oRdAddr
oRdAddr  out  XA_W+YA_W  frame-buffer read address {yScaled, xScaled}
oRdEn  out  1  read strobe
oPixelX  out  10  current horizontal count
oPixelY  out  10  current vertical count
oHsync  out  1  active-low horizontal sync
oVsync  out  1  active-low vertical sync
oRed, oGreen, oBlue  out  1 each  pixel colour
oDisplayEn  out  1  high while output pixel is visible
oFrameStart  out  1  one-Clock pulse at frame wrap

Behaviour:
- Clock is the only clock. Reset is synchronous and active-high. Reset has priority over iEnable.
- Reset values: divider 0; oPixelX=0; oPixelY=0; oHsync=1; oVsync=1; RGB=0; oDisplayEn=0; oFrameStart=0.
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Pixel tick: asserted for one Clock when divider == CLK_DIV-1. The divider then wraps to 0.
- On each tick, oPixelX increments; at H_TOTAL-1 it wraps to 0 and oPixelY increments. oPixelY wraps from V_TOTAL-1 to 0.
- Region order per axis: visible [0, VIS), front porch, sync pulse, back porch.
- iEnable=0: divider, X and Y hold at 0; syncs held 1; RGB 0; oDisplayEn 0; oRdEn 0.
- Deasserting iEnable mid-frame restarts the next enabled frame at (0,0).
- Read scheduling (combinational from the counters):
  - oRdEn = iEnable & (X<H_VISIBLE) & (Y<V_VISIBLE).
  - oRdAddr = {Y>>SCALE_SHIFT truncated to YA_W, X>>SCALE_SHIFT truncated to XA_W}.
  - oRdAddr is 0 when oRdEn=0.
- Output pipeline: all outputs below are registered at the tick that advances the counters past (X,Y), so every pin is exactly one pixel tick behind the counters and mutually aligned.
  - HSync = 0 iff H_VISIBLE+H_FP <= X < H_VISIBLE+H_FP+H_PW.
  - VSync = 0 iff V_VISIBLE+V_FP <= Y < V_VISIBLE+V_FP+V_PW. VSync is whole-line aligned.
  - oDisplayEn = visible(X,Y).
  - RGB = iRdData if visible, else 000.
  - iRdData is sampled at that tick. This is valid because CLK_DIV>=2 guarantees at least one Clock of read latency.
- oFrameStart: high for the single Clock in which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Counter width: 10 bits. All compares are unsigned. Parameter sums must fit in 10 bits.
- Reset mid-line: all state returns to reset values on the next Clock edge. The scan resumes from (0,0) with no partial-line artefacts.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 default constants, the H_TOTAL/V_TOTAL derivations, and the colour encoding (bit2=R, bit1=G, bit0=B).
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). Parameters: VIS, FP, PW, BP. Inputs: Clock, Reset, advance. Outputs: count, wrap, visible, syncActive.

Test Plan:
- Reset, iEnable=1 -> oHsync falls 1314 Clocks after the first tick at (0,0) (X=656 reached, plus one-tick output delay) and stays low 192 Clocks. Line period is 1600 Clocks.
- Full frame -> oVsync low exactly 3200 Clocks, starting at line 490. oFrameStart pulses every 840000 Clocks. oDisplayEn high 640x2 Clocks per visible line, 480 lines.
- Memory model returns addr[2:0]; at counters X=17, Y=9 -> oRdAddr=130 ({6'd1, 7'd2}), oRdEn=1. Next tick, RGB=010.
- iRdData held 111 -> RGB=000 whenever X>=640 or Y>=480; oRdEn=0 there.
- Reset asserted at X=300, Y=200 -> next Clock: X=0, Y=0, syncs 1, RGB 0. The scan then repeats the first-line timing exactly.
- iEnable dropped mid-frame for 100 Clocks -> outputs idle, counters 0. After re-enable, the first HSync falls 1314 Clocks later.
